// File: rtl/id_ex_pipe_reg_n.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg_n
// Parametrised ID->EX pipeline register for a LANES-wide superscalar core.
// Lane 0 is the oldest slot and occupies the LSBs of every packed bus.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   i_StallE            hold every E-stage field
//   i_FlushE[LANES]     per-lane flush request (optionally squashes younger lanes)
//   i_ValidD[LANES]     D-stage lane carries a real instruction
//   i_CtrlD             per lane {PCSrc,RegWrite,MemtoReg,MemWrite,Branch,ALUSrc,FlagWrite}
//   i_ALUControlD, i_CondD, i_FlagsD, i_RdD      per-lane decode fields
//   i_RDaD, i_RDbD, i_ExtendD                    per-lane D_WIDTH operands
//   i_CntClr            synchronous clear of the bubble counter
//   o_*E                registered E-stage copies of the D-side fields
//   o_BubbleCnt         saturating count of bubble lane-cycles
// -----------------------------------------------------------------------------
module id_ex_pipe_reg_n #(
    parameter int LANES          = 2,
    parameter int D_WIDTH        = 32,
    parameter int SQUASH_YOUNGER = 1,
    parameter int CNT_W          = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_StallE,
    input  logic [LANES-1:0]           i_FlushE,
    input  logic [LANES-1:0]           i_ValidD,
    input  logic [LANES*7-1:0]         i_CtrlD,
    input  logic [LANES*2-1:0]         i_ALUControlD,
    input  logic [LANES*4-1:0]         i_CondD,
    input  logic [LANES*4-1:0]         i_FlagsD,
    input  logic [LANES*4-1:0]         i_RdD,
    input  logic [LANES*D_WIDTH-1:0]   i_RDaD,
    input  logic [LANES*D_WIDTH-1:0]   i_RDbD,
    input  logic [LANES*D_WIDTH-1:0]   i_ExtendD,
    input  logic                       i_CntClr,
    output logic [LANES-1:0]           o_ValidE,
    output logic [LANES*7-1:0]         o_CtrlE,
    output logic [LANES*2-1:0]         o_ALUControlE,
    output logic [LANES*4-1:0]         o_CondE,
    output logic [LANES*4-1:0]         o_FlagsE,
    output logic [LANES*4-1:0]         o_RdE,
    output logic [LANES*D_WIDTH-1:0]   o_RDaE,
    output logic [LANES*D_WIDTH-1:0]   o_RDbE,
    output logic [LANES*D_WIDTH-1:0]   o_ExtendE,
    output logic [CNT_W-1:0]           o_BubbleCnt
);

    // Lane-count width; the +1 keeps it at least two bits wide for LANES=1.
    localparam int BW     = $clog2(LANES + 1) + 1;
    localparam int SUM_W  = CNT_W + BW;
    localparam bit SQUASH = (SQUASH_YOUNGER != 0);

    logic [LANES-1:0] flush_eff_s;
    logic [LANES-1:0] bubble_s;
    logic [BW-1:0]    bubble_cnt_s;
    logic [SUM_W-1:0] cnt_sum_s;
    logic             cnt_sat_s;

    // Population count of the per-lane bubble vector.
    function automatic logic [BW-1:0] count_ones(input logic [LANES-1:0] v);
        logic [BW-1:0] n;
        n = {BW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            n = n + {{(BW-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Effective flush: in squash mode a flush on any older lane also kills this lane.
    always_comb begin
        logic older_flush_v;
        older_flush_v = 1'b0;
        flush_eff_s   = {LANES{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            flush_eff_s[k] = i_FlushE[k] | (SQUASH & older_flush_v);
            older_flush_v  = older_flush_v | i_FlushE[k];
        end
    end

    // A lane is a bubble when flushed, or when it loads an invalid slot; stalled lanes do not count.
    always_comb begin
        bubble_s = flush_eff_s | ({LANES{~i_StallE}} & ~i_ValidD);
    end

    assign bubble_cnt_s = count_ones(bubble_s);
    // Sum is computed BW bits wider so an overflow is visible before it wraps.
    assign cnt_sum_s    = {{BW{1'b0}}, o_BubbleCnt} + {{CNT_W{1'b0}}, bubble_cnt_s};
    assign cnt_sat_s    = (cnt_sum_s > {{BW{1'b0}}, {CNT_W{1'b1}}});

    // Per-lane E-stage registers: flush beats stall beats load; RdE survives a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_ValidE      <= {LANES{1'b0}};
            o_CtrlE       <= {(LANES*7){1'b0}};
            o_ALUControlE <= {(LANES*2){1'b0}};
            o_CondE       <= {(LANES*4){1'b0}};
            o_FlagsE      <= {(LANES*4){1'b0}};
            o_RdE         <= {(LANES*4){1'b0}};
            o_RDaE        <= {(LANES*D_WIDTH){1'b0}};
            o_RDbE        <= {(LANES*D_WIDTH){1'b0}};
            o_ExtendE     <= {(LANES*D_WIDTH){1'b0}};
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (flush_eff_s[k]) begin
                    o_ValidE[k]                   <= 1'b0;
                    o_CtrlE[k*7 +: 7]             <= 7'b0;
                    o_ALUControlE[k*2 +: 2]       <= 2'b0;
                    o_CondE[k*4 +: 4]             <= 4'b0;
                    o_FlagsE[k*4 +: 4]            <= 4'b0;
                    o_RDaE[k*D_WIDTH +: D_WIDTH]    <= {D_WIDTH{1'b0}};
                    o_RDbE[k*D_WIDTH +: D_WIDTH]    <= {D_WIDTH{1'b0}};
                    o_ExtendE[k*D_WIDTH +: D_WIDTH] <= {D_WIDTH{1'b0}};
                end else if (!i_StallE) begin
                    o_ValidE[k]                   <= i_ValidD[k];
                    o_CtrlE[k*7 +: 7]             <= i_CtrlD[k*7 +: 7];
                    o_ALUControlE[k*2 +: 2]       <= i_ALUControlD[k*2 +: 2];
                    o_CondE[k*4 +: 4]             <= i_CondD[k*4 +: 4];
                    o_FlagsE[k*4 +: 4]            <= i_FlagsD[k*4 +: 4];
                    o_RdE[k*4 +: 4]               <= i_RdD[k*4 +: 4];
                    o_RDaE[k*D_WIDTH +: D_WIDTH]    <= i_RDaD[k*D_WIDTH +: D_WIDTH];
                    o_RDbE[k*D_WIDTH +: D_WIDTH]    <= i_RDbD[k*D_WIDTH +: D_WIDTH];
                    o_ExtendE[k*D_WIDTH +: D_WIDTH] <= i_ExtendD[k*D_WIDTH +: D_WIDTH];
                end
            end
        end
    end

    // Bubble counter: clear wins over increment, otherwise saturating add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_BubbleCnt <= {CNT_W{1'b0}};
        end else if (i_CntClr) begin
            o_BubbleCnt <= {CNT_W{1'b0}};
        end else if (cnt_sat_s) begin
            o_BubbleCnt <= {CNT_W{1'b1}};
        end else begin
            o_BubbleCnt <= cnt_sum_s[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg_n.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe_reg_n
// Three instances share one stimulus: u_dut (defaults), u_dut_ns (independent
// per-lane flush) and u_dut_c4 (4-bit bubble counter). Each test task pushes its
// expectations into a scoreboard queue while driving, then pops and compares
// once the DUT has produced the registered result.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe_reg_n;

    typedef struct {
        string       name;
        logic [63:0] exp;
    } sb_t;

    logic clk_s;
    logic rst_n_s;
    logic stall_s, cnt_clr_s;
    logic [1:0]  flush_s, valid_d_s, alu_d_s_hi, alu_d_s_lo;
    logic [13:0] ctrl_d_s;
    logic [3:0]  alu_d_s;
    logic [7:0]  cond_d_s, flags_d_s, rd_d_s;
    logic [63:0] rda_d_s, rdb_d_s, ext_d_s;

    // Outputs of the three instances (_a default, _n no-squash, _c 4-bit counter)
    logic [1:0]  valid_a_s, valid_n_s, valid_c_s;
    logic [13:0] ctrl_a_s, ctrl_n_s, ctrl_c_s;
    logic [3:0]  alu_a_s, alu_n_s, alu_c_s;
    logic [7:0]  cond_a_s, cond_n_s, cond_c_s, flags_a_s, flags_n_s, flags_c_s;
    logic [7:0]  rd_a_s, rd_n_s, rd_c_s;
    logic [63:0] rda_a_s, rda_n_s, rda_c_s, rdb_a_s, rdb_n_s, rdb_c_s;
    logic [63:0] ext_a_s, ext_n_s, ext_c_s;
    logic [15:0] cnt_a_s, cnt_n_s;
    logic [3:0]  cnt_c_s;

    sb_t         sb_q[$];
    logic [63:0] obs_q[$];
    sb_t         e;
    int          tests_run    = 0;
    int          tests_failed = 0;
    int          exp_cnt_a    = 0;
    int          exp_cnt_n    = 0;
    int          exp_cnt_c    = 0;

    id_ex_pipe_reg_n u_dut (
        .clk(clk_s), .rst_n(rst_n_s), .i_StallE(stall_s), .i_FlushE(flush_s),
        .i_ValidD(valid_d_s), .i_CtrlD(ctrl_d_s), .i_ALUControlD(alu_d_s),
        .i_CondD(cond_d_s), .i_FlagsD(flags_d_s), .i_RdD(rd_d_s),
        .i_RDaD(rda_d_s), .i_RDbD(rdb_d_s), .i_ExtendD(ext_d_s), .i_CntClr(cnt_clr_s),
        .o_ValidE(valid_a_s), .o_CtrlE(ctrl_a_s), .o_ALUControlE(alu_a_s),
        .o_CondE(cond_a_s), .o_FlagsE(flags_a_s), .o_RdE(rd_a_s),
        .o_RDaE(rda_a_s), .o_RDbE(rdb_a_s), .o_ExtendE(ext_a_s), .o_BubbleCnt(cnt_a_s)
    );

    id_ex_pipe_reg_n #(.SQUASH_YOUNGER(0)) u_dut_ns (
        .clk(clk_s), .rst_n(rst_n_s), .i_StallE(stall_s), .i_FlushE(flush_s),
        .i_ValidD(valid_d_s), .i_CtrlD(ctrl_d_s), .i_ALUControlD(alu_d_s),
        .i_CondD(cond_d_s), .i_FlagsD(flags_d_s), .i_RdD(rd_d_s),
        .i_RDaD(rda_d_s), .i_RDbD(rdb_d_s), .i_ExtendD(ext_d_s), .i_CntClr(cnt_clr_s),
        .o_ValidE(valid_n_s), .o_CtrlE(ctrl_n_s), .o_ALUControlE(alu_n_s),
        .o_CondE(cond_n_s), .o_FlagsE(flags_n_s), .o_RdE(rd_n_s),
        .o_RDaE(rda_n_s), .o_RDbE(rdb_n_s), .o_ExtendE(ext_n_s), .o_BubbleCnt(cnt_n_s)
    );

    id_ex_pipe_reg_n #(.CNT_W(4)) u_dut_c4 (
        .clk(clk_s), .rst_n(rst_n_s), .i_StallE(stall_s), .i_FlushE(flush_s),
        .i_ValidD(valid_d_s), .i_CtrlD(ctrl_d_s), .i_ALUControlD(alu_d_s),
        .i_CondD(cond_d_s), .i_FlagsD(flags_d_s), .i_RdD(rd_d_s),
        .i_RDaD(rda_d_s), .i_RDbD(rdb_d_s), .i_ExtendD(ext_d_s), .i_CntClr(cnt_clr_s),
        .o_ValidE(valid_c_s), .o_CtrlE(ctrl_c_s), .o_ALUControlE(alu_c_s),
        .o_CondE(cond_c_s), .o_FlagsE(flags_c_s), .o_RdE(rd_c_s),
        .o_RDaE(rda_c_s), .o_RDbE(rdb_c_s), .o_ExtendE(ext_c_s), .o_BubbleCnt(cnt_c_s)
    );

    // 10 ns clock
    initial begin
        clk_s = 1'b0;
        forever #5 clk_s = ~clk_s;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic push(input string n, input logic [63:0] v);
        sb_t s;
        s.name = n;
        s.exp  = v;
        sb_q.push_back(s);
    endtask

    // Expected bubble counters, advanced with hand-derived per-edge bubble counts.
    task automatic model(input int b_sq, input int b_ns, input bit clr);
        if (clr) begin
            exp_cnt_a = 0; exp_cnt_n = 0; exp_cnt_c = 0;
        end else begin
            exp_cnt_a = exp_cnt_a + b_sq;
            exp_cnt_n = exp_cnt_n + b_ns;
            exp_cnt_c = (exp_cnt_c + b_sq > 15) ? 15 : exp_cnt_c + b_sq;
        end
    endtask

    task automatic set_lane(input int k, input logic v, input logic [6:0] c, input logic [1:0] a,
                            input logic [3:0] cd, input logic [3:0] f, input logic [3:0] rd,
                            input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] ex);
        valid_d_s[k]        = v;
        ctrl_d_s[k*7 +: 7]  = c;
        alu_d_s[k*2 +: 2]   = a;
        cond_d_s[k*4 +: 4]  = cd;
        flags_d_s[k*4 +: 4] = f;
        rd_d_s[k*4 +: 4]    = rd;
        rda_d_s[k*32 +: 32] = ra;
        rdb_d_s[k*32 +: 32] = rb;
        ext_d_s[k*32 +: 32] = ex;
    endtask

    task automatic clear_inputs();
        stall_s = 1'b0; flush_s = 2'b00; cnt_clr_s = 1'b0;
        set_lane(0, 1'b0, 7'h0, 2'h0, 4'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0);
        set_lane(1, 1'b0, 7'h0, 2'h0, 4'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst_n_s = 1'b0;
        clear_inputs();
        tick(); tick();
        push("rst_valid", 64'd0); push("rst_ctrl", 64'd0); push("rst_rd", 64'd0);
        push("rst_rda", 64'd0); push("rst_cnt", 64'd0); push("rst_cnt_c4", 64'd0);
        obs_q.push_back(64'(valid_a_s)); obs_q.push_back(64'(ctrl_a_s)); obs_q.push_back(64'(rd_a_s));
        obs_q.push_back(rda_a_s); obs_q.push_back(64'(cnt_a_s)); obs_q.push_back(64'(cnt_c_s));
        for (int i = 0; i < obs_q.size(); i++) begin
            e = sb_q.pop_front(); tests_run++;
            if (obs_q[i] !== e.exp) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.exp); end
        end
        obs_q.delete();

        // Load a value, then drop reset between edges
        rst_n_s = 1'b1;
        set_lane(0, 1'b1, 7'h11, 2'h1, 4'h1, 4'h1, 4'h3, 32'hDEADBEEF, 32'h1, 32'h2);
        set_lane(1, 1'b1, 7'h12, 2'h2, 4'h2, 4'h2, 4'h4, 32'h5, 32'h6, 32'h7);
        model(0, 0, 1'b0);
        push("load_rda0", 64'hDEADBEEF); push("load_valid", 64'd3);
        tick();
        obs_q.push_back(64'(rda_a_s[31:0])); obs_q.push_back(64'(valid_a_s));
        for (int i = 0; i < obs_q.size(); i++) begin
            e = sb_q.pop_front(); tests_run++;
            if (obs_q[i] !== e.exp) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.exp); end
        end
        obs_q.delete();

        #3 rst_n_s = 1'b0;
        model(0, 0, 1'b1);
        #1;
        push("midrst_valid", 64'd0); push("midrst_rda", 64'd0); push("midrst_rd", 64'd0);
        push("midrst_ctrl", 64'd0); push("midrst_cnt", 64'd0);
        obs_q.push_back(64'(valid_a_s)); obs_q.push_back(rda_a_s); obs_q.push_back(64'(rd_a_s));
        obs_q.push_back(64'(ctrl_a_s)); obs_q.push_back(64'(cnt_a_s));
        for (int i = 0; i < obs_q.size(); i++) begin
            e = sb_q.pop_front(); tests_run++;
            if (obs_q[i] !== e.exp) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.exp); end
        end
        obs_q.delete();
        tick();
        rst_n_s = 1'b1;
    endtask

    task automatic test_pass_through();
        set_lane(0, 1'b1, 7'h15, 2'h1, 4'h2, 4'h3, 4'h1, 32'hAAAA0000, 32'hBBBB0000, 32'hCCCC0000);
        set_lane(1, 1'b1, 7'h7F, 2'h2, 4'h9, 4'h5, 4'hA, 32'h11111111, 32'h22222222, 32'h12345678);
        // Nothing may appear before the edge
        push("pre_edge_ext", 64'd0);
        obs_q.push_back(ext_a_s);
        model(0, 0, 1'b0);
        push("pt_valid", 64'd3); push("pt_ctrl1", 64'h7F); push("pt_alu1", 64'd2);
        push("pt_cond1", 64'h9); push("pt_flags1", 64'h5); push("pt_rd1", 64'hA);
        push("pt_rda1", 64'h11111111); push("pt_rdb1", 64'h22222222); push("pt_ext1", 64'h12345678);
        push("pt_rd0", 64'h1); push("pt_cnt", 64'(exp_cnt_a));
        tick();
        obs_q.push_back(64'(valid_a_s)); obs_q.push_back(64'(ctrl_a_s[13:7])); obs_q.push_back(64'(alu_a_s[3:2]));
        obs_q.push_back(64'(cond_a_s[7:4])); obs_q.push_back(64'(flags_a_s[7:4])); obs_q.push_back(64'(rd_a_s[7:4]));
        obs_q.push_back(64'(rda_a_s[63:32])); obs_q.push_back(64'(rdb_a_s[63:32])); obs_q.push_back(64'(ext_a_s[63:32]));
        obs_q.push_back(64'(rd_a_s[3:0])); obs_q.push_back(64'(cnt_a_s));
        for (int i = 0; i < obs_q.size(); i++) begin
            e = sb_q.pop_front(); tests_run++;
            if (obs_q[i] !== e.exp) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.exp); end
        end
        obs_q.delete();
    endtask

    task automatic test_stall();
        stall_s = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_lane(0, 1'b0, 7'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                     $urandom, $urandom, $urandom);
            set_lane(1, 1'b0, 7'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                     $urandom, $urandom, $urandom);
            model(0, 0, 1'b0);
            push("stall_valid", 64'd3); push("stall_ctrl1", 64'h7F); push("stall_ext1", 64'h12345678);
            push("stall_rda0", 64'hAAAA0000); push("stall_rd1", 64'hA); push("stall_cnt", 64'(exp_cnt_a));
            tick();
            obs_q.push_back(64'(valid_a_s)); obs_q.push_back(64'(ctrl_a_s[13:7])); obs_q.push_back(64'(ext_a_s[63:32]));
            obs_q.push_back(64'(rda_a_s[31:0])); obs_q.push_back(64'(rd_a_s[7:4])); obs_q.push_back(64'(cnt_a_s));
            for (int i = 0; i < obs_q.size(); i++) begin
                e = sb_q.pop_front(); tests_run++;
                if (obs_q[i] !== e.exp) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.exp); end
            end
            obs_q.delete();
        end
        // Release: fresh values land on the next edge
        stall_s = 1'b0;
        set_lane(0, 1'b1, 7'h22, 2'h3, 4'h4, 4'h6, 4'h4, 32'h10101010, 32'h20202020, 32'h30303030);
        set_lane(1, 1'b1, 7'h33, 2'h0, 4'h7, 4'h8, 4'h7, 32'h40404040, 32'h50505050, 32'h60606060);
        model(0, 0, 1'b0);
        push("rel_valid", 64'd3); push("rel_rd", 64'h74); push("rel_ctrl", 64'({7'h33, 7'h22}));
        push("rel_ext0", 64'h30303030); push("rel_cnt", 64'(exp_cnt_a));
        tick();
        obs_q.push_back(64'(valid_a_s)); obs_q.push_back(64'(rd_a_s)); obs_q.push_back(64'(ctrl_a_s));
        obs_q.push_back(64'(ext_a_s[31:0])); obs_q.push_back(64'(cnt_a_s));
        for (int i = 0; i < obs_q.size(); i++) begin
            e = sb_q.pop_front(); tests_run++;
            if (obs_q[i] !== e.exp) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.exp); end
        end
        obs_q.delete();
    endtask

    task automatic test_flush_stall();
        // Lane-0 flush under stall: squash kills both lanes, independent mode only lane 0
        stall_s = 1'b1; flush_s = 2'b01;
        set_lane(0, 1'b1, 7'h44, 2'h1, 4'h1, 4'h1, 4'hE, 32'hE0E0E0E0, 32'h1, 32'h2);
        set_lane(1, 1'b1, 7'h55, 2'h1, 4'h1, 4'h1, 4'hF, 32'hF0F0F0F0, 32'h3, 32'h4);
        model(2, 1, 1'b0);
        push("fs_valid", 64'd0); push("fs_ctrl", 64'd0); push("fs_rd_held", 64'h74);
        push("fs_rda", 64'd0); push("fs_ext", 64'd0); push("fs_cnt", 64'(exp_cnt_a));
        push("fs_ns_valid", 64'd2); push("fs_ns_ctrl0", 64'd0); push("fs_ns_ctrl1", 64'h33);
        push("fs_ns_rd", 64'h74); push("fs_ns_rda1", 64'h40404040); push("fs_ns_cnt", 64'(exp_cnt_n));
        push("fs_c4_cnt", 64'(exp_cnt_c));
        tick();
        obs_q.push_back(64'(valid_a_s)); obs_q.push_back(64'(ctrl_a_s)); obs_q.push_back(64'(rd_a_s));
        obs_q.push_back(rda_a_s); obs_q.push_back(ext_a_s); obs_q.push_back(64'(cnt_a_s));
        obs_q.push_back(64'(valid_n_s)); obs_q.push_back(64'(ctrl_n_s[6:0])); obs_q.push_back(64'(ctrl_n_s[13:7]));
        obs_q.push_back(64'(rd_n_s)); obs_q.push_back(64'(rda_n_s[63:32])); obs_q.push_back(64'(cnt_n_s));
        obs_q.push_back(64'(cnt_c_s));
        for (int i = 0; i < obs_q.size(); i++) begin
            e = sb_q.pop_front(); tests_run++;
            if (obs_q[i] !== e.exp) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.exp); end
        end
        obs_q.delete();

        // Reload both lanes
        stall_s = 1'b0; flush_s = 2'b00;
        set_lane(0, 1'b1, 7'h0A, 2'h1, 4'h1, 4'h1, 4'h2, 32'h0A0A0A0A, 32'h1, 32'h2);
        set_lane(1, 1'b1, 7'h0B, 2'h2, 4'h2, 4'h2, 4'h3, 32'h0B0B0B0B, 32'h3, 32'h4);
        model(0, 0, 1'b0);
        push("rl_valid", 64'd3); push("rl_ns_valid", 64'd3); push("rl_ns_rd", 64'h32);
        tick();
        obs_q.push_back(64'(valid_a_s)); obs_q.push_back(64'(valid_n_s)); obs_q.push_back(64'(rd_n_s));
        for (int i = 0; i < obs_q.size(); i++) begin
            e = sb_q.pop_front(); tests_run++;
            if (obs_q[i] !== e.exp) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.exp); end
        end
        obs_q.delete();

        // Lane-1 flush under stall: lane 1 cleared, lane 0 held, in both modes
        stall_s = 1'b1; flush_s = 2'b10;
        set_lane(0, 1'b1, 7'h66, 2'h3, 4'h3, 4'h3, 4'h5, 32'h66666666, 32'h1, 32'h2);
        set_lane(1, 1'b1, 7'h77, 2'h3, 4'h3, 4'h3, 4'h6, 32'h77777777, 32'h3, 32'h4);
        model(1, 1, 1'b0);
        push("f1_valid", 64'd1); push("f1_ns_valid", 64'd1); push("f1_ns_rd", 64'h32);
        push("f1_ns_rda0", 64'h0A0A0A0A); push("f1_ns_rda1", 64'd0); push("f1_ctrl1", 64'd0);
        push("f1_ctrl0", 64'h0A); push("f1_cnt", 64'(exp_cnt_a)); push("f1_ns_cnt", 64'(exp_cnt_n));
        tick();
        obs_q.push_back(64'(valid_a_s)); obs_q.push_back(64'(valid_n_s)); obs_q.push_back(64'(rd_n_s));
        obs_q.push_back(64'(rda_n_s[31:0])); obs_q.push_back(64'(rda_n_s[63:32])); obs_q.push_back(64'(ctrl_a_s[13:7]));
        obs_q.push_back(64'(ctrl_a_s[6:0])); obs_q.push_back(64'(cnt_a_s)); obs_q.push_back(64'(cnt_n_s));
        for (int i = 0; i < obs_q.size(); i++) begin
            e = sb_q.pop_front(); tests_run++;
            if (obs_q[i] !== e.exp) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.exp); end
        end
        obs_q.delete();

        // Lane-0 flush without stall: squash mode kills lane 1 too, independent mode loads it
        stall_s = 1'b0; flush_s = 2'b01;
        set_lane(0, 1'b1, 7'h0C, 2'h1, 4'h1, 4'h1, 4'h8, 32'h0C0C0C0C, 32'h1, 32'h2);
        set_lane(1, 1'b1, 7'h0D, 2'h1, 4'h1, 4'h1, 4'h9, 32'h0D0D0D0D, 32'h3, 32'h4);
        model(2, 1, 1'b0);
        push("sq_valid", 64'd0); push("sq_rd", 64'h32); push("sq_ns_valid", 64'd2);
        push("sq_ns_rd", 64'h92); push("sq_ns_rda1", 64'h0D0D0D0D); push("sq_ns_rda0", 64'd0);
        push("sq_cnt", 64'(exp_cnt_a)); push("sq_ns_cnt", 64'(exp_cnt_n)); push("sq_c4_cnt", 64'(exp_cnt_c));
        tick();
        obs_q.push_back(64'(valid_a_s)); obs_q.push_back(64'(rd_a_s)); obs_q.push_back(64'(valid_n_s));
        obs_q.push_back(64'(rd_n_s)); obs_q.push_back(64'(rda_n_s[63:32])); obs_q.push_back(64'(rda_n_s[31:0]));
        obs_q.push_back(64'(cnt_a_s)); obs_q.push_back(64'(cnt_n_s)); obs_q.push_back(64'(cnt_c_s));
        for (int i = 0; i < obs_q.size(); i++) begin
            e = sb_q.pop_front(); tests_run++;
            if (obs_q[i] !== e.exp) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.exp); end
        end
        obs_q.delete();
        flush_s = 2'b00;
    endtask

    task automatic test_per_lane_invalid();
        set_lane(0, 1'b0, 7'h5A, 2'h2, 4'h3, 4'h4, 4'hC, 32'h55AA55AA, 32'h66, 32'h77);
        set_lane(1, 1'b1, 7'h01, 2'h0, 4'h0, 4'h0, 4'hD, 32'h99999999, 32'h88, 32'h99);
        model(1, 1, 1'b0);
        push("inv_valid", 64'd2); push("inv_ctrl0", 64'h5A); push("inv_rda0", 64'h55AA55AA);
        push("inv_rd", 64'hDC); push("inv_cnt", 64'(exp_cnt_a)); push("inv_ns_cnt", 64'(exp_cnt_n));
        tick();
        obs_q.push_back(64'(valid_a_s)); obs_q.push_back(64'(ctrl_a_s[6:0])); obs_q.push_back(64'(rda_a_s[31:0]));
        obs_q.push_back(64'(rd_a_s)); obs_q.push_back(64'(cnt_a_s)); obs_q.push_back(64'(cnt_n_s));
        for (int i = 0; i < obs_q.size(); i++) begin
            e = sb_q.pop_front(); tests_run++;
            if (obs_q[i] !== e.exp) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.exp); end
        end
        obs_q.delete();
    endtask

    task automatic test_saturation();
        valid_d_s = 2'b00;
        for (int c = 0; c < 10; c++) begin
            model(2, 2, 1'b0);
            push("sat_c4_cnt", 64'(exp_cnt_c)); push("sat_cnt", 64'(exp_cnt_a));
            tick();
            obs_q.push_back(64'(cnt_c_s)); obs_q.push_back(64'(cnt_a_s));
            for (int i = 0; i < obs_q.size(); i++) begin
                e = sb_q.pop_front(); tests_run++;
                if (obs_q[i] !== e.exp) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.exp); end
            end
            obs_q.delete();
        end
        // Clear beats the pending +2
        cnt_clr_s = 1'b1;
        model(2, 2, 1'b1);
        push("clr_c4_cnt", 64'd0); push("clr_cnt", 64'd0); push("clr_ns_cnt", 64'd0);
        tick();
        obs_q.push_back(64'(cnt_c_s)); obs_q.push_back(64'(cnt_a_s)); obs_q.push_back(64'(cnt_n_s));
        for (int i = 0; i < obs_q.size(); i++) begin
            e = sb_q.pop_front(); tests_run++;
            if (obs_q[i] !== e.exp) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.exp); end
        end
        obs_q.delete();
        // Counting resumes after the clear
        cnt_clr_s = 1'b0;
        model(2, 2, 1'b0);
        push("post_clr_c4_cnt", 64'(exp_cnt_c));
        tick();
        obs_q.push_back(64'(cnt_c_s));
        for (int i = 0; i < obs_q.size(); i++) begin
            e = sb_q.pop_front(); tests_run++;
            if (obs_q[i] !== e.exp) begin tests_failed++; $display("FAIL %s: got %h, expected %h", e.name, obs_q[i], e.exp); end
        end
        obs_q.delete();
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_pass_through();
        test_stall();
        test_flush_stall();
        test_per_lane_invalid();
        test_saturation();
        if (sb_q.size() != 0) begin
            tests_run++; tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
